// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states; bit 1 set means a grant is outstanding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Requester slots.
  localparam int REQ_EXEC  = 0;
  localparam int REQ_FETCH = 1;
  localparam int REQ_DBG   = 2;

  // Add a small offset to a requester index and wrap modulo n (n <= 4).
  function automatic logic [1:0] idx_add(input logic [1:0] base,
                                         input logic [1:0] off,
                                         input int unsigned n);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (32'(s) >= n) s = s - 3'(n);
    return s[1:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational grantee selector: round-robin from a pointer, or fixed
// lowest-index-wins priority.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int FIXED_PRIO = 0
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_ptr,
  output logic [1:0]      o_idx,
  output logic            o_vld
);

  logic [1:0]      w_start;
  logic [NREQ-1:0] w_rot;

  // Fixed priority is just round-robin that always starts at slot 0.
  assign w_start = (FIXED_PRIO != 0) ? 2'd0 : i_ptr;

  // Rotate so that bit k of w_rot is requester (start + k) mod NREQ.
  assign w_rot = NREQ'({i_req, i_req} >> w_start);

  // First set bit of the rotated vector, mapped back to a requester index.
  always_comb begin
    o_vld = 1'b0;
    o_idx = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_vld && w_rot[k]) begin
        o_vld = 1'b1;
        o_idx = idx_add(w_start, 2'(k), NREQ);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single external memory port between exec, fetch and the
// debug/loader port. One transaction at a time, grant locked until the
// requester acknowledges completion by dropping req; a watchdog aborts
// transactions the memory never answers.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int TIMEOUT    = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0]    req_we,
  output logic [NREQ-1:0]    ready,
  output logic               err,
  output logic [DW-1:0]      rdata,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic               mem_req,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_data_out,
  output logic               mem_we,
  input  logic               mem_ready,
  input  logic [DW-1:0]      mem_data_in
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_ready;
  logic            r_err;
  logic [DW-1:0]   r_rdata;
  logic [1:0]      r_gid;
  logic            r_mreq;
  logic [AW-1:0]   r_maddr;
  logic [DW-1:0]   r_mdout;
  logic            r_mwe;

  logic [1:0]      w_pick_idx;
  logic            w_pick_vld;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic            w_sel_we;
  logic [NREQ-1:0] w_gnt_mask;
  logic            w_req_g;
  logic            w_timeout;

  rr_pick #(
    .NREQ       (NREQ),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  // Extract the candidate grantee's address, write data and direction.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_idx == 2'(i)) begin
        w_sel_addr  = req_addr[i*AW +: AW];
        w_sel_wdata = req_wdata[i*DW +: DW];
        w_sel_we    = req_we[i];
      end
    end
  end

  assign w_gnt_mask = NREQ'(1) << r_gid;
  assign w_req_g    = |(req & w_gnt_mask);
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // Arbiter FSM: grant in IDLE, wait for memory or watchdog in BUSY,
  // hold ready in DONE until the grantee lets go of req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_ready <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_gid   <= 2'd0;
      r_mreq  <= 1'b0;
      r_maddr <= '0;
      r_mdout <= '0;
      r_mwe   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_gid   <= w_pick_idx;
            r_maddr <= w_sel_addr;
            r_mdout <= w_sel_wdata;
            r_mwe   <= w_sel_we;
            r_mreq  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          // A memory answer beats a watchdog expiry in the same cycle.
          if (mem_ready) begin
            if (!r_mwe) r_rdata <= mem_data_in;
            r_mreq  <= 1'b0;
            r_mwe   <= 1'b0;
            r_ready <= w_gnt_mask;
            r_err   <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            r_mreq  <= 1'b0;
            r_rdata <= '1;
            r_ready <= w_gnt_mask;
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!w_req_g) begin
            r_ready <= '0;
            r_err   <= 1'b0;
            r_ptr   <= idx_add(r_gid, 2'd1, NREQ);
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready        = r_ready;
  assign err          = r_err;
  assign rdata        = r_rdata;
  assign grant_id     = r_gid;
  assign busy         = (r_state == ST_BUSY) || (r_state == ST_DONE);
  assign mem_req      = r_mreq;
  assign mem_addr     = r_maddr;
  assign mem_data_out = r_mdout;
  assign mem_we       = r_mwe;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction scoreboard and a
// behavioural memory that answers addr ^ 0x4A after a programmable delay
// and never answers address 0x44.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int         NREQ = 3;
  localparam int         TO   = 16;
  localparam logic [7:0] DEAD = 8'h44;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req, req_we, ready;
  logic [23:0] req_addr, req_wdata;
  logic        err, busy, mem_req, mem_we, mem_ready;
  logic [7:0]  rdata, mem_addr, mem_data_out, mem_data_in;
  logic [1:0]  grant_id;

  logic [2:0]  fp_req, fp_req_we, fp_ready;
  logic [23:0] fp_req_addr, fp_req_wdata;
  logic        fp_err, fp_busy, fp_mem_req, fp_mem_we, fp_mem_ready;
  logic [7:0]  fp_rdata, fp_mem_addr, fp_mem_data_out, fp_mem_data_in;
  logic [1:0]  fp_grant_id;

  mem_arbiter #(.NREQ(NREQ), .AW(8), .DW(8), .TIMEOUT(TO), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_we(req_we), .ready(ready), .err(err), .rdata(rdata), .grant_id(grant_id),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_data_in(mem_data_in));

  mem_arbiter #(.NREQ(NREQ), .AW(8), .DW(8), .TIMEOUT(TO), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .req(fp_req), .req_addr(fp_req_addr), .req_wdata(fp_req_wdata),
    .req_we(fp_req_we), .ready(fp_ready), .err(fp_err), .rdata(fp_rdata),
    .grant_id(fp_grant_id), .busy(fp_busy), .mem_req(fp_mem_req), .mem_addr(fp_mem_addr),
    .mem_data_out(fp_mem_data_out), .mem_we(fp_mem_we), .mem_ready(fp_mem_ready),
    .mem_data_in(fp_mem_data_in));

  typedef struct {
    int         id;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_last;
  int         checks = 0;
  int         errors = 0;
  int         mem_lat, lat_cnt, fp_lat_cnt, mreq_len;
  logic       prev_mreq;
  logic [2:0] prev_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one transaction, pushed in predicted grant order.
  task automatic push(input int id, input logic [7:0] addr, input logic we, input logic [7:0] wd);
    exp_t e;
    e.id = id; e.addr = addr; e.we = we; e.wdata = wd;
    e.err = (addr == DEAD);
    if (e.err) exp_last = 8'hFF;
    else if (!we) exp_last = addr ^ 8'h4A;
    e.rdata = exp_last;
    sb.push_back(e);
  endtask

  task automatic drive(input int id, input logic [7:0] addr, input logic we, input logic [7:0] wd);
    req_addr[id*8 +: 8]  = addr;
    req_wdata[id*8 +: 8] = wd;
    req_we[id]           = we;
    req[id]              = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_mreq = 1'b0; prev_rdy = '0; mreq_len = 0;
      return;
    end
    if (mem_req && !prev_mreq) begin
      mreq_len = 1;
      chk("grant_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk("grant_id", 32'(grant_id), 32'(e.id));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.we) chk("mem_data_out", 32'(mem_data_out), 32'(e.wdata));
      end
    end else if (mem_req) begin
      mreq_len++;
    end
    if (ready != 3'b000 && prev_rdy == 3'b000) begin
      chk("ready_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ready_vec", 32'(ready), 32'(3'b001 << e.id));
        chk("err", 32'(err), 32'(e.err));
        chk("rdata", 32'(rdata), 32'(e.rdata));
        chk("busy_done", 32'(busy), 32'd1);
        if (e.err) chk("watchdog_len", 32'(mreq_len), 32'(TO));
      end
    end
    prev_mreq = mem_req;
    prev_rdy  = ready;
  endtask

  // Advance to the next falling edge, update both memory models, then monitor.
  task automatic tick();
    @(negedge clk);
    if (mem_ready) begin
      mem_ready = 1'b0; lat_cnt = 0;
    end else if (mem_req && mem_addr != DEAD) begin
      if (lat_cnt >= mem_lat) begin
        mem_ready = 1'b1; mem_data_in = mem_addr ^ 8'h4A; lat_cnt = 0;
      end else lat_cnt++;
    end else lat_cnt = 0;
    if (fp_mem_ready) begin
      fp_mem_ready = 1'b0; fp_lat_cnt = 0;
    end else if (fp_mem_req) begin
      if (fp_lat_cnt >= 1) begin
        fp_mem_ready = 1'b1; fp_mem_data_in = fp_mem_addr ^ 8'h4A; fp_lat_cnt = 0;
      end else fp_lat_cnt++;
    end else fp_lat_cnt = 0;
    monitor();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready == 3'b000 && n < 100) begin tick(); n++; end
    chk(tag, 32'(ready != 3'b000), 32'd1);
  endtask

  task automatic wait_fp_ready(input string tag);
    int n = 0;
    while (fp_ready == 3'b000 && n < 100) begin tick(); n++; end
    chk(tag, 32'(fp_ready != 3'b000), 32'd1);
  endtask

  initial begin
    logic [2:0] rdy_seen;
    rst = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    fp_req = '0; fp_req_we = '0; fp_req_addr = '0; fp_req_wdata = '0;
    mem_ready = 1'b0; mem_data_in = '0; fp_mem_ready = 1'b0; fp_mem_data_in = '0;
    mem_lat = 1; lat_cnt = 0; fp_lat_cnt = 0; mreq_len = 0;
    prev_mreq = 1'b0; prev_rdy = '0; exp_last = 8'h00;

    // Reset values.
    #1;
    chk("reset_ctrl", 32'({ready, err, busy, mem_req, mem_we}), 32'd0);
    chk("reset_data", {rdata, mem_addr, mem_data_out, 6'd0, grant_id}, 32'd0);
    chk("reset_fp", 32'({fp_ready, fp_err, fp_busy, fp_mem_req, fp_grant_id}), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single read from fetch, memory answers two cycles after the grant.
    mem_lat = 1;
    push(REQ_FETCH, 8'h10, 1'b0, 8'h00);
    drive(REQ_FETCH, 8'h10, 1'b0, 8'h00);
    @(posedge clk); #1;
    chk("latency_mem_req", 32'(mem_req), 32'd1);
    wait_ready("read_wait");
    repeat (3) tick();
    chk("read_ready_hold", 32'(ready), 32'(3'b010));
    chk("read_err_hold", 32'(err), 32'd0);
    req[REQ_FETCH] = 1'b0;
    tick();
    chk("read_ready_drop", 32'(ready), 32'd0);
    chk("read_idle", 32'(busy), 32'd0);
    chk("grant_id_hold", 32'(grant_id), 32'(REQ_FETCH));
    chk("read_rdata", 32'(rdata), 32'h5A);

    // A stray memory answer while idle is ignored.
    mem_ready = 1'b1; mem_data_in = 8'h77;
    tick(); tick();
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_rdata", 32'(rdata), 32'h5A);
    chk("idle_ack_ready", 32'(ready), 32'd0);

    // Write from exec; request fields change after the grant.
    mem_lat = 2;
    push(REQ_EXEC, 8'h3F, 1'b1, 8'hC3);
    drive(REQ_EXEC, 8'h3F, 1'b1, 8'hC3);
    tick();
    req_addr[7:0] = 8'h00; req_wdata[7:0] = 8'h00; req_we[0] = 1'b0;
    tick();
    chk("write_addr_latched", 32'(mem_addr), 32'h3F);
    chk("write_we_latched", 32'(mem_we), 32'd1);
    chk("write_data_latched", 32'(mem_data_out), 32'hC3);
    wait_ready("write_wait");
    req[REQ_EXEC] = 1'b0;
    tick();

    // Debug read with a same-cycle memory answer; leaves the pointer at 0.
    mem_lat = 0;
    push(REQ_DBG, 8'h2D, 1'b0, 8'h00);
    drive(REQ_DBG, 8'h2D, 1'b0, 8'h00);
    wait_ready("dbg_wait");
    req[REQ_DBG] = 1'b0;
    tick();

    // Round-robin contention: expected grants 0,1,2,0.
    mem_lat = 1;
    push(0, 8'h20, 1'b0, 8'h00);
    push(1, 8'h21, 1'b0, 8'h00);
    push(2, 8'h22, 1'b0, 8'h00);
    push(0, 8'h20, 1'b0, 8'h00);
    drive(0, 8'h20, 1'b0, 8'h00);
    drive(1, 8'h21, 1'b0, 8'h00);
    drive(2, 8'h22, 1'b0, 8'h00);
    for (int n = 0; n < 4; n++) begin
      wait_ready("rr_wait");
      rdy_seen = ready;
      req = req & ~rdy_seen;
      tick();
      if (n == 0) req[0] = 1'b1;
    end
    chk("rr_drained", 32'(sb.size()), 32'd0);

    // Watchdog on fetch to a dead address, then debug served normally.
    push(REQ_FETCH, DEAD, 1'b0, 8'h00);
    push(REQ_DBG, 8'h55, 1'b0, 8'h00);
    drive(REQ_FETCH, DEAD, 1'b0, 8'h00);
    drive(REQ_DBG, 8'h55, 1'b0, 8'h00);
    wait_ready("wd_wait");
    chk("wd_mem_req_low", 32'(mem_req), 32'd0);
    req[REQ_FETCH] = 1'b0;
    tick();
    wait_ready("wd_next_wait");
    req[REQ_DBG] = 1'b0;
    tick();

    // Fetch read moves the pointer to 2 before the reset test.
    push(REQ_FETCH, 8'h66, 1'b0, 8'h00);
    drive(REQ_FETCH, 8'h66, 1'b0, 8'h00);
    wait_ready("pre_rst_wait");
    req[REQ_FETCH] = 1'b0;
    tick();

    // Asynchronous reset while debug is stuck in BUSY.
    push(REQ_DBG, DEAD, 1'b0, 8'h00);
    drive(REQ_DBG, DEAD, 1'b0, 8'h00);
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_ready_err", 32'({ready, err}), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    tick(); tick();
    exp_last = 8'h00;
    req_addr[23:16] = 8'h31;
    drive(REQ_EXEC, 8'h30, 1'b0, 8'h00);
    push(REQ_EXEC, 8'h30, 1'b0, 8'h00);
    push(REQ_DBG, 8'h31, 1'b0, 8'h00);
    rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wait_ready("post_rst_wait");
      rdy_seen = ready;
      req = req & ~rdy_seen;
      tick();
    end
    chk("post_rst_drained", 32'(sb.size()), 32'd0);

    // Fixed priority: exec re-requests at once and keeps winning over fetch.
    fp_req_addr = {8'h00, 8'h81, 8'h80};
    fp_req = 3'b011;
    for (int n = 0; n < 4; n++) begin
      wait_fp_ready("fp_wait");
      chk("fp_ready_exec", 32'(fp_ready), 32'(3'b001));
      chk("fp_grant_exec", 32'(fp_grant_id), 32'd0);
      chk("fp_rdata_exec", 32'(fp_rdata), 32'hCA);
      fp_req[0] = 1'b0;
      tick();
      if (n < 3) fp_req[0] = 1'b1;
    end
    wait_fp_ready("fp_fetch_wait");
    chk("fp_ready_fetch", 32'(fp_ready), 32'(3'b010));
    chk("fp_rdata_fetch", 32'(fp_rdata), 32'hCB);
    fp_req[1] = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single external memory port between multiple requesters: CPU exec stage, fetch stage, and a debug/loader port. Arbitrates round-robin (or fixed priority), locks the grant for one full transaction, and drives the registered memory-side handshake. It returns read data and a per-requester ready. A watchdog aborts transactions whose memory never answers.

Parameters:
NREQ, 3, number of requesters (2..4); index 0 = exec, 1 = fetch, 2 = debug
AW, 8, address width
DW, 8, data width
TIMEOUT, 16, max cycles in BUSY before abort; 0 disables watchdog
FIXED_PRIO, 0, 1 = lowest index always wins; 0 = round-robin

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  per-requester request level
req_addr  in  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
req_wdata  in  NREQ*DW  flattened write data
req_we  in  NREQ  per-requester write enable
ready  out  NREQ  per-requester completion, held until that req drops
err  out  1  high with ready when the transaction was aborted by the watchdog
rdata  out  DW  read data of last completed transaction
grant_id  out  2  index of current or last grantee
busy  out  1  high in BUSY or DONE
mem_req  out  1  memory request
mem_addr  out  AW  memory address
mem_data_out  out  DW  memory write data
mem_we  out  1  memory write enable
mem_ready  in  1  memory completion
mem_data_in  in  DW  memory read data

Behaviour:
- Reset values (async): all outputs 0; state IDLE; rr pointer 0; watchdog counter 0.
- Requester contract: raise req with addr, wdata and we stable; hold until ready=1; then drop req. The arbiter latches addr, wdata and we at grant, so later changes are ignored.
- IDLE:
  - If any req is set, select a grantee g:
    - FIXED_PRIO=1: lowest set index.
    - FIXED_PRIO=0: first set index at or above the pointer, wrapping modulo NREQ.
  - At the same edge: latch the request into mem_addr, mem_data_out and mem_we; set mem_req=1, grant_id=g; clear the counter; go to BUSY.
  - Latency: req high before edge 1 gives mem_req high after edge 1.
- BUSY:
  - mem_req held at 1; the counter increments each cycle.
  - If mem_ready=1 at an edge: rdata<=mem_data_in (reads only; writes leave rdata unchanged); mem_req<=0; mem_we<=0; ready[g]<=1; err<=0; go to DONE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without mem_ready: mem_req<=0; rdata<={DW{1'b1}}; ready[g]<=1; err<=1; go to DONE.
  - mem_ready and the timeout in the same cycle: mem_ready wins, err=0.
- DONE:
  - ready[g] and err are held while req[g]=1.
  - At the first edge with req[g]=0: ready[g]<=0; err<=0; pointer<=(g+1) mod NREQ; go to IDLE.
  - The next grant occurs no earlier than the following edge, so back-to-back transactions take at least 3 cycles plus memory latency.
- If a requester drops req during BUSY, the transaction still completes. ready pulses for exactly one cycle in DONE.
- mem_ready received while in IDLE or DONE is ignored.
- At most one ready bit is set at any time; at most one grant is outstanding.
- Asynchronous reset mid-transaction: mem_req, ready and err drop immediately. The requester must re-issue.
- grant_id holds its value after DONE until the next grant.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding ST_IDLE=2'b00, ST_BUSY=2'b10, ST_DONE=2'b11, matching the stage-state convention.
  - requester index constants REQ_EXEC=0, REQ_FETCH=1, REQ_DBG=2.
- One sub-module, rr_pick: combinational round-robin/fixed selector. Inputs req vector, pointer and FIXED_PRIO; outputs index and valid.
- The FSM, latches and watchdog stay in mem_arbiter.

Test Plan:
- Single read: fetch req, addr 0x10; memory answers 0x5A after 2 cycles -> mem_addr=0x10, mem_we=0, rdata=0x5A, ready[1]=1 until req drops, err=0.
- Contention round-robin: all three req held continuously, pointer 0 -> grants ordered 0,1,2,0; grant_id sequence matches; no overlap of ready bits.
- Fixed priority: FIXED_PRIO=1, req 0 and 1 both re-asserted immediately after each completion -> requester 0 always granted, requester 1 starves.
- Write: exec req_we=1, addr 0x3F, wdata 0xC3 -> mem_we=1, mem_data_out=0xC3 during BUSY; rdata unchanged after completion.
- Watchdog: TIMEOUT=16, mem_ready never asserted -> mem_req drops after 16 BUSY cycles, ready[g]=1, err=1, rdata=0xFF; the next requester is served normally.
- Reset mid-BUSY: assert rst asynchronously between edges -> mem_req, ready and busy go 0 immediately; after release, the pending req is granted from pointer 0.
